// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the 5-stage pipeline: sequencer states,
// register-zero constant and stage control-field widths.
package cpu_pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } pipe_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // Widths of the WB and M control fields carried down the pipe.
    localparam int WB_W = 2;
    localparam int M_W  = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use comparator: flags an IF/ID instruction that reads the
// destination of a load still sitting in ID/EX. Writes to $0 never hazard.
module hazard_detect
    import cpu_pipe_pkg::*;
(
    input  logic       idex_mem_read,
    input  logic [4:0] idex_rt,
    input  logic [4:0] ifid_rs,
    input  logic [4:0] ifid_rt,
    output logic       lu
);

    // One-cycle bubble is needed when the loaded register is consumed next.
    always_comb begin
        lu = idex_mem_read && (idex_rt != REG_ZERO) &&
             ((idex_rt == ifid_rs) || (idex_rt == ifid_rt));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline sequencer: PC / stage-register enables, bubbles and
// flushes for load-use, taken branches (resolved in MEM) and slow data
// memory, with a watchdog that latches a sticky memory error.
//
// Control outputs are combinational from state and inputs. Inputs are
// masked by rst_n so that while reset is held the block looks like an idle
// RUN state: every stage writes, nothing is bubbled or flushed.
module pipe_hazard_ctrl
    import cpu_pipe_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       ifid_rs,
    input  logic [4:0]       ifid_rt,
    input  logic             idex_mem_read,
    input  logic [4:0]       idex_rt,
    input  logic             exmem_branch,
    input  logic             exmem_zero,
    input  logic             exmem_mem_read,
    input  logic             exmem_mem_write,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             exmem_write,
    output logic             exmem_flush,
    output logic             memwb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(MEM_TIMEOUT - 1);

    pipe_state_e     state;
    logic [WC_W-1:0] wait_cnt;
    logic            lu_raw;
    logic            mem_acc;
    logic            take;
    logic            lu;
    logic            rdy;
    logic            freeze;

    hazard_detect u_hazard_detect (
        .idex_mem_read (idex_mem_read),
        .idex_rt       (idex_rt),
        .ifid_rs       (ifid_rs),
        .ifid_rt       (ifid_rt),
        .lu            (lu_raw)
    );

    // Qualified hazard terms; all forced low while reset is asserted.
    always_comb begin
        mem_acc = rst_n & (exmem_mem_read | exmem_mem_write);
        take    = rst_n & exmem_branch & exmem_zero;
        lu      = rst_n & lu_raw;
        rdy     = rst_n & mem_ready;
    end

    // Output mux: memory freeze beats branch redirect beats load-use stall.
    always_comb begin
        pc_write     = 1'b1;
        pc_src       = 1'b0;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_write   = 1'b1;
        idex_bubble  = 1'b0;
        exmem_write  = 1'b1;
        exmem_flush  = 1'b0;
        memwb_bubble = 1'b0;
        case (state)
            ST_ERROR:    freeze = 1'b1;
            ST_MEM_WAIT: freeze = !rdy;
            default:     freeze = mem_acc & !rdy;
        endcase
        if (freeze) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_write   = 1'b0;
            exmem_write  = 1'b0;
            memwb_bubble = 1'b1;
        end else if (take) begin
            // Squash the three younger instructions; the dependent one of a
            // load-use pair goes with them, so no stall is needed as well.
            pc_src      = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            exmem_flush = 1'b1;
        end else if (lu) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    // Sequencer FSM with memory-wait watchdog and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (mem_acc && !mem_ready) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= WC_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    if (!mem_ready) begin
                        wait_cnt <= wait_cnt + WC_W'(1);
                        if (wait_cnt == WC_LAST) begin
                            state   <= ST_ERROR;
                            mem_err <= 1'b1;
                        end
                    end else begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end
                end
                ST_ERROR: begin
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= ST_RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a short watchdog and a 4-bit
// stall counter so timeout and saturation are reachable quickly.
module tb_pipe_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 4;

    // Packed control view: pc_write, pc_src, ifid_write, ifid_flush,
    // idex_write, idex_bubble, exmem_write, exmem_flush, memwb_bubble.
    localparam logic [8:0] C_NORM   = 9'b1_0_1_0_1_0_1_0_0;
    localparam logic [8:0] C_LU     = 9'b0_0_0_0_1_1_1_0_0;
    localparam logic [8:0] C_TAKE   = 9'b1_1_1_1_1_1_1_1_0;
    localparam logic [8:0] C_FREEZE = 9'b0_0_0_0_0_0_0_0_1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       ifid_rs;
    logic [4:0]       ifid_rt;
    logic             idex_mem_read;
    logic [4:0]       idex_rt;
    logic             exmem_branch;
    logic             exmem_zero;
    logic             exmem_mem_read;
    logic             exmem_mem_write;
    logic             mem_ready;
    logic             pc_write;
    logic             pc_src;
    logic             ifid_write;
    logic             ifid_flush;
    logic             idex_write;
    logic             idex_bubble;
    logic             exmem_write;
    logic             exmem_flush;
    logic             memwb_bubble;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [8:0]       ctrl;

    int total;
    int bad;

    assign ctrl = {pc_write, pc_src, ifid_write, ifid_flush, idex_write,
                   idex_bubble, exmem_write, exmem_flush, memwb_bubble};

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ifid_rs         (ifid_rs),
        .ifid_rt         (ifid_rt),
        .idex_mem_read   (idex_mem_read),
        .idex_rt         (idex_rt),
        .exmem_branch    (exmem_branch),
        .exmem_zero      (exmem_zero),
        .exmem_mem_read  (exmem_mem_read),
        .exmem_mem_write (exmem_mem_write),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .pc_src          (pc_src),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_write      (idex_write),
        .idex_bubble     (idex_bubble),
        .exmem_write     (exmem_write),
        .exmem_flush     (exmem_flush),
        .memwb_bubble    (memwb_bubble),
        .mem_err         (mem_err),
        .stall_cycles    (stall_cycles)
    );

    // Clock: 10 ns period, first rising edge at 5 ns.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        ifid_rs         = 5'd0;
        ifid_rt         = 5'd0;
        idex_mem_read   = 1'b0;
        idex_rt         = 5'd0;
        exmem_branch    = 1'b0;
        exmem_zero      = 1'b0;
        exmem_mem_read  = 1'b0;
        exmem_mem_write = 1'b0;
        mem_ready       = 1'b0;
    endtask

    // Advance one rising edge, then land 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #2;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_ctrl", 32'(ctrl), 32'(C_NORM));
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Reset state, including inputs that would otherwise freeze.
        #3;
        exmem_mem_read = 1'b1;
        exmem_branch   = 1'b1;
        exmem_zero     = 1'b1;
        #1;
        chk("reset_ctrl", 32'(ctrl), 32'(C_NORM));
        chk("reset_err", 32'(mem_err), 32'd0);
        chk("reset_stall", 32'(stall_cycles), 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        settle();
        chk("idle_ctrl", 32'(ctrl), 32'(C_NORM));

        // Load-use on rs: one-cycle stall.
        idex_mem_read = 1'b1;
        idex_rt       = 5'd5;
        ifid_rs       = 5'd5;
        settle();
        chk("lu_rs_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        idle_inputs();
        settle();
        chk("lu_rs_after", 32'(ctrl), 32'(C_NORM));
        chk("lu_rs_stall", 32'(stall_cycles), 32'd1);

        // Load-use on rt.
        idex_mem_read = 1'b1;
        idex_rt       = 5'd7;
        ifid_rs       = 5'd3;
        ifid_rt       = 5'd7;
        settle();
        chk("lu_rt_ctrl", 32'(ctrl), 32'(C_LU));
        tick();
        idle_inputs();
        chk("lu_rt_stall", 32'(stall_cycles), 32'd2);

        // Load to $0 never stalls; unrelated registers do not either.
        idex_mem_read = 1'b1;
        settle();
        chk("lu_zero_ctrl", 32'(ctrl), 32'(C_NORM));
        idex_rt = 5'd9;
        ifid_rs = 5'd8;
        ifid_rt = 5'd10;
        settle();
        chk("lu_miss_ctrl", 32'(ctrl), 32'(C_NORM));
        tick();
        chk("lu_zero_stall", 32'(stall_cycles), 32'd2);

        // Taken branch together with a load-use: branch wins, no stall.
        idex_rt      = 5'd8;
        exmem_branch = 1'b1;
        exmem_zero   = 1'b1;
        settle();
        chk("take_lu_ctrl", 32'(ctrl), 32'(C_TAKE));
        tick();
        chk("take_lu_stall", 32'(stall_cycles), 32'd2);
        // Branch not taken: the load-use stall takes effect.
        exmem_zero = 1'b0;
        settle();
        chk("ntake_lu_ctrl", 32'(ctrl), 32'(C_LU));
        idle_inputs();
        settle();

        // Zero-wait access; mem_ready without an access is ignored.
        exmem_mem_write = 1'b1;
        mem_ready       = 1'b1;
        settle();
        chk("zw_ctrl", 32'(ctrl), 32'(C_NORM));
        tick();
        exmem_mem_write = 1'b0;
        settle();
        chk("rdy_noacc_ctrl", 32'(ctrl), 32'(C_NORM));
        tick();
        chk("zw_stall", 32'(stall_cycles), 32'd2);

        // Memory wait: 3 frozen cycles, release on the 4th with a branch.
        pulse_reset();
        idle_inputs();
        exmem_mem_read = 1'b1;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk($sformatf("wait_ctrl%0d", i), 32'(ctrl), 32'(C_FREEZE));
            tick();
        end
        mem_ready    = 1'b1;
        exmem_branch = 1'b1;
        exmem_zero   = 1'b1;
        settle();
        chk("release_take", 32'(ctrl), 32'(C_TAKE));
        tick();
        chk("wait_stall", 32'(stall_cycles), 32'd3);
        idle_inputs();
        settle();
        chk("wait_back_run", 32'(ctrl), 32'(C_NORM));

        // Timeout: ERROR after MEM_TIMEOUT frozen cycles.
        exmem_mem_write = 1'b1;
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            settle();
            chk($sformatf("to_ctrl%0d", i), 32'(ctrl), 32'(C_FREEZE));
            chk($sformatf("to_err%0d", i), 32'(mem_err), 32'd0);
            tick();
        end
        chk("to_err_set", 32'(mem_err), 32'd1);
        chk("to_stall", 32'(stall_cycles), 32'd7);
        mem_ready = 1'b1;
        settle();
        chk("err_ready_ctrl", 32'(ctrl), 32'(C_FREEZE));
        tick();
        chk("err_sticky", 32'(mem_err), 32'd1);
        chk("err_stall", 32'(stall_cycles), 32'd8);

        // Saturation while held in ERROR.
        idle_inputs();
        for (int i = 0; i < 20; i++) tick();
        chk("sat_stall", 32'(stall_cycles), 32'd15);
        tick();
        chk("sat_hold", 32'(stall_cycles), 32'd15);
        chk("sat_err", 32'(mem_err), 32'd1);

        // Reset clears the error; then a reset mid-wait clears wait_cnt.
        pulse_reset();
        settle();
        chk("post_err_ctrl", 32'(ctrl), 32'(C_NORM));
        exmem_mem_read = 1'b1;
        tick();
        tick();
        pulse_reset();
        settle();
        chk("midwait_run", 32'(ctrl), 32'(C_FREEZE));
        for (int i = 0; i < MEM_TIMEOUT - 1; i++) tick();
        chk("midwait_cnt_clr", 32'(mem_err), 32'd0);
        mem_ready = 1'b1;
        settle();
        chk("midwait_release", 32'(ctrl), 32'(C_NORM));
        tick();
        chk("midwait_stall", 32'(stall_cycles), 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
